alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for a combinational 16-bit ALU: accepts instruction words, decodes them
// into ALU control/operands, captures the result and writes it back to an 8x16 register file.
module alu_issue_ctrl #(
   parameter bit ZERO_REG   = 1'b0,
   parameter bit IMM_SIGNED = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr_word,
   output logic [4:0]  alu_ctrl,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_result,
   output logic        done,
   output logic        err_illegal,
   output logic        err_div0,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   localparam int NUM_REGS = 8;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_XOR = 5'b00100;
   localparam logic [4:0] OP_MUL = 5'b00101;
   localparam logic [4:0] OP_DIV = 5'b00111;
   localparam logic [4:0] OP_NOT = 5'b01000;
   localparam logic [4:0] OP_MOD = 5'b01001;
   localparam logic [4:0] OP_LDI = 5'b01010;
   localparam logic [4:0] OP_CEQ = 5'b01100;
   localparam logic [4:0] OP_CNE = 5'b01101;
   localparam logic [4:0] OP_CGT = 5'b01110;
   localparam logic [4:0] OP_CLT = 5'b01111;
   localparam logic [4:0] OP_CGE = 5'b10000;
   localparam logic [4:0] OP_CLE = 5'b10001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_e;

   function automatic logic op_is_legal(input logic [4:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_NOT,
         OP_MOD, OP_LDI, OP_CEQ, OP_CNE, OP_CGT, OP_CLT, OP_CGE, OP_CLE: legal = 1'b1;
         default:                                                         legal = 1'b0;
      endcase
      return legal;
   endfunction

   // r0 reads as zero when it is hardwired
   function automatic logic [15:0] read_reg(input logic [2:0] addr, input logic [15:0] val);
      logic [15:0] rd;
      if (ZERO_REG && (addr == 3'd0)) begin
         rd = 16'h0000;
      end else begin
         rd = val;
      end
      return rd;
   endfunction

   function automatic logic [15:0] ext_imm(input logic [7:0] imm);
      logic [15:0] ext;
      if (IMM_SIGNED) begin
         ext = {{8{imm[7]}}, imm};
      end else begin
         ext = {8'h00, imm};
      end
      return ext;
   endfunction

   state_e       state_q, state_d;
   logic [15:0]  instr_q, instr_d;
   logic [4:0]   alu_ctrl_q, alu_ctrl_d;
   logic [15:0]  alu_a_q, alu_a_d;
   logic [15:0]  alu_b_q, alu_b_d;
   logic [15:0]  result_q, result_d;
   logic         legal_q, legal_d;
   logic         div0_q, div0_d;
   logic         done_q, done_d;
   logic         err_illegal_q, err_illegal_d;
   logic         err_div0_q, err_div0_d;
   logic [15:0]  regs_q [NUM_REGS];
   logic [15:0]  regs_d [NUM_REGS];

   logic         instr_ready_s;
   logic         decode_s;
   logic         exec_s;
   logic         wb_s;
   logic         accept_s;
   logic         wr_en_s;
   logic [4:0]   op_s;
   logic [2:0]   dst_s;
   logic [2:0]   src_a_s;
   logic [2:0]   src_b_s;
   logic [15:0]  opnd_a_s;
   logic [15:0]  opnd_b_s;

   assign op_s    = instr_q[15:11];
   assign dst_s   = instr_q[10:8];
   assign src_a_s = instr_q[7:5];
   assign src_b_s = instr_q[4:2];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: IDLE waits for a handshake, the other states last one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               state_d = ST_DECODE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WB;
         ST_WB:     state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: per-state strobes
   always_comb begin
      instr_ready_s = 1'b0;
      decode_s      = 1'b0;
      exec_s        = 1'b0;
      wb_s          = 1'b0;
      case (state_q)
         ST_IDLE:   instr_ready_s = 1'b1;
         ST_DECODE: decode_s      = 1'b1;
         ST_EXEC:   exec_s        = 1'b1;
         ST_WB:     wb_s          = 1'b1;
         default:   instr_ready_s = 1'b0;
      endcase
   end

   assign accept_s = instr_ready_s & instr_valid;

   // Operand selection; LDI replaces B with the extended immediate
   always_comb begin
      opnd_a_s = read_reg(src_a_s, regs_q[src_a_s]);
      if (op_s == OP_LDI) begin
         opnd_b_s = ext_imm(instr_q[7:0]);
      end else begin
         opnd_b_s = read_reg(src_b_s, regs_q[src_b_s]);
      end
   end

   // Datapath next values: latch word, issue operands, classify, capture result
   always_comb begin
      instr_d    = instr_q;
      alu_ctrl_d = alu_ctrl_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      legal_d    = legal_q;
      div0_d     = div0_q;
      result_d   = result_q;
      if (accept_s) begin
         instr_d = instr_word;
      end else begin
         instr_d = instr_q;
      end
      if (decode_s) begin
         alu_ctrl_d = op_s;
         alu_a_d    = opnd_a_s;
         alu_b_d    = opnd_b_s;
         legal_d    = op_is_legal(op_s);
         div0_d     = ((op_s == OP_DIV) || (op_s == OP_MOD)) && (opnd_b_s == 16'h0000);
      end else begin
         alu_ctrl_d = alu_ctrl_q;
         alu_a_d    = alu_a_q;
         alu_b_d    = alu_b_q;
         legal_d    = legal_q;
         div0_d     = div0_q;
      end
      if (exec_s) begin
         result_d = alu_result;
      end else begin
         result_d = result_q;
      end
   end

   // Completion and error flags pulse in the cycle after writeback
   always_comb begin
      done_d        = wb_s;
      err_illegal_d = wb_s & ~legal_q;
      err_div0_d    = wb_s & legal_q & div0_q;
   end

   assign wr_en_s = wb_s & legal_q & ~div0_q & ~(ZERO_REG & (dst_s == 3'd0));

   // Register file next state
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en_s) begin
         regs_d[dst_s] = result_q;
      end else begin
         regs_d[dst_s] = regs_q[dst_s];
      end
   end

   // Datapath and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q       <= 16'h0000;
         alu_ctrl_q    <= 5'b00000;
         alu_a_q       <= 16'h0000;
         alu_b_q       <= 16'h0000;
         result_q      <= 16'h0000;
         legal_q       <= 1'b0;
         div0_q        <= 1'b0;
         done_q        <= 1'b0;
         err_illegal_q <= 1'b0;
         err_div0_q    <= 1'b0;
      end else begin
         instr_q       <= instr_d;
         alu_ctrl_q    <= alu_ctrl_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         result_q      <= result_d;
         legal_q       <= legal_d;
         div0_q        <= div0_d;
         done_q        <= done_d;
         err_illegal_q <= err_illegal_d;
         err_div0_q    <= err_div0_d;
      end
   end

   // Register file storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign instr_ready = instr_ready_s;
   assign alu_ctrl    = alu_ctrl_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign done        = done_q;
   assign err_illegal = err_illegal_q;
   assign err_div0    = err_div0_q;
   assign dbg_data    = read_reg(dbg_addr, regs_q[dbg_addr]);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (plain and ZERO_REG/IMM_SIGNED) driven by the same
// stream, checked every cycle against a transaction-level model of the instruction set.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr_word = 16'h0000;
   logic [2:0]  dbg_addr = 3'd0;

   logic        ir0, done0, eill0, edz0;
   logic        ir1, done1, eill1, edz1;
   logic [4:0]  ctrl0, ctrl1;
   logic [15:0] a0, b0, res0, dbg0;
   logic [15:0] a1, b1, res1, dbg1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [4:0] legal_ops [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8,
                                  5'd9, 5'd10, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};

   // Reference ALU behaviour (the partner block), also used by the model
   function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a & b;
         5'd3:  return a | b;
         5'd4:  return a ^ b;
         5'd5:  return 16'((32'(a) * 32'(b)) & 32'h0000FFFF);
         5'd7:  return (b == 16'h0) ? 16'hDEAD : a / b;
         5'd8:  return ~a;
         5'd9:  return (b == 16'h0) ? 16'hDEAD : a % b;
         5'd10: return b;
         5'd12: return {15'h0, a == b};
         5'd13: return {15'h0, a != b};
         5'd14: return {15'h0, a > b};
         5'd15: return {15'h0, a < b};
         5'd16: return {15'h0, a >= b};
         5'd17: return {15'h0, a <= b};
         default: return 16'h0000;
      endcase
   endfunction

   assign res0 = alu_f(ctrl0, a0, b0);
   assign res1 = alu_f(ctrl1, a1, b1);

   alu_issue_ctrl #(.ZERO_REG(1'b0), .IMM_SIGNED(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ir0),
      .instr_word(instr_word), .alu_ctrl(ctrl0), .alu_a(a0), .alu_b(b0),
      .alu_result(res0), .done(done0), .err_illegal(eill0), .err_div0(edz0),
      .dbg_addr(dbg_addr), .dbg_data(dbg0));

   alu_issue_ctrl #(.ZERO_REG(1'b1), .IMM_SIGNED(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ir1),
      .instr_word(instr_word), .alu_ctrl(ctrl1), .alu_a(a1), .alu_b(b1),
      .alu_result(res1), .done(done1), .err_illegal(eill1), .err_div0(edz1),
      .dbg_addr(dbg_addr), .dbg_data(dbg1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          done_at;
      logic [4:0]  op;
      logic [2:0]  dst;
      logic        legal;
      logic [15:0] ea0, eb0, er0;
      logic        dz0;
      logic [15:0] ea1, eb1, er1;
      logic        dz1;
   } exp_t;

   exp_t        q[$];
   logic [15:0] m0 [8];
   logic [15:0] m1 [8];
   int          busy_until = 0;

   function automatic logic is_legal(input logic [4:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] mread(input bit inst, input logic [2:0] ad);
      if (inst) return (ad == 3'd0) ? 16'h0000 : m1[ad];
      return m0[ad];
   endfunction

   function automatic exp_t predict(input logic [15:0] w, input int at);
      exp_t e;
      logic [7:0] imm;
      imm       = w[7:0];
      e.done_at = at;
      e.op      = w[15:11];
      e.dst     = w[10:8];
      e.legal   = is_legal(e.op);
      e.ea0     = mread(1'b0, w[7:5]);
      e.ea1     = mread(1'b1, w[7:5]);
      e.eb0     = (e.op == 5'd10) ? {8'h00, imm} : mread(1'b0, w[4:2]);
      e.eb1     = (e.op == 5'd10) ? {{8{imm[7]}}, imm} : mread(1'b1, w[4:2]);
      e.dz0     = e.legal && (e.op == 5'd7 || e.op == 5'd9) && e.eb0 == 16'h0;
      e.dz1     = e.legal && (e.op == 5'd7 || e.op == 5'd9) && e.eb1 == 16'h0;
      e.er0     = alu_f(e.op, e.ea0, e.eb0);
      e.er1     = alu_f(e.op, e.ea1, e.eb1);
      return e;
   endfunction

   // Compare process: every falling edge, DUT outputs against the model
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         busy_until = 0;
         foreach (m0[i]) begin m0[i] = 16'h0; m1[i] = 16'h0; end
         chk("rst_ready0", ir0, 1); chk("rst_ready1", ir1, 1);
         chk("rst_done0", done0, 0); chk("rst_done1", done1, 0);
         chk("rst_err0", {eill0, edz0}, 0); chk("rst_err1", {eill1, edz1}, 0);
         chk("rst_ctrl0", ctrl0, 0); chk("rst_a0", a0, 0); chk("rst_b0", b0, 0);
         chk("rst_ctrl1", ctrl1, 0); chk("rst_a1", a1, 0); chk("rst_b1", b1, 0);
      end else begin
         if (q.size() > 0 && q[0].done_at == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("done0", done0, 1); chk("done1", done1, 1);
            chk("err_illegal0", eill0, !e.legal); chk("err_illegal1", eill1, !e.legal);
            chk("err_div0_0", edz0, e.dz0); chk("err_div0_1", edz1, e.dz1);
            chk("alu_ctrl0", ctrl0, e.op); chk("alu_ctrl1", ctrl1, e.op);
            chk("alu_a0", a0, e.ea0); chk("alu_b0", b0, e.eb0);
            chk("alu_a1", a1, e.ea1); chk("alu_b1", b1, e.eb1);
            if (e.legal && !e.dz0) m0[e.dst] = e.er0;
            if (e.legal && !e.dz1 && e.dst != 3'd0) m1[e.dst] = e.er1;
         end else begin
            chk("idle_done0", {done0, eill0, edz0}, 0);
            chk("idle_done1", {done1, eill1, edz1}, 0);
         end
         chk("ready0", ir0, cyc >= busy_until);
         chk("ready1", ir1, cyc >= busy_until);
         chk("dbg0", dbg0, mread(1'b0, dbg_addr));
         chk("dbg1", dbg1, mread(1'b1, dbg_addr));
         if (instr_valid && cyc >= busy_until) begin
            q.push_back(predict(instr_word, cyc + 4));
            busy_until = cyc + 4;
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] d,
                                       input logic [2:0] sa, input logic [2:0] sb);
      return {op, d, sa, sb, 2'b00};
   endfunction

   function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
      return {5'd10, d, imm};
   endfunction

   task automatic issue(input logic [15:0] w);
      int t = 0;
      @(posedge clk); #1;
      instr_word  = w;
      instr_valid = 1'b1;
      @(negedge clk);
      while (!ir0 && t < 40) begin @(negedge clk); t++; end
      if (!ir0) chk("issue_timeout", ir0, 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!ir0 && t < 40) begin @(negedge clk); t++; end
      if (!ir0) chk("ready_timeout", ir0, 1);
      #1;
   endtask

   task automatic dbg_lit(input string nm, input logic [2:0] ad, input logic [15:0] e0,
                          input logic [15:0] e1);
      dbg_addr = ad; #1;
      chk({nm, "_i0"}, dbg0, e0);
      chk({nm, "_i1"}, dbg1, e1);
   endtask

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("lit_reset_ready", ir0, 1);
      for (int i = 0; i < 8; i++) dbg_lit("lit_reset_reg", 3'(i), 16'h0, 16'h0);

      issue(ldi(3'd1, 8'h05)); issue(ldi(3'd2, 8'h03)); issue(enc(5'd0, 3'd3, 3'd1, 3'd2));
      wait_ready(); dbg_lit("lit_add_r3", 3'd3, 16'h0008, 16'h0008);
      issue(enc(5'd5, 3'd4, 3'd1, 3'd2));
      wait_ready(); dbg_lit("lit_mul_r4", 3'd4, 16'h000F, 16'h000F);

      issue(enc(5'd8, 3'd1, 3'd0, 3'd0)); issue(ldi(3'd2, 8'h02));
      issue(enc(5'd0, 3'd5, 3'd1, 3'd2));
      wait_ready(); dbg_lit("lit_wrap_r5", 3'd5, 16'h0001, 16'h0001);
      issue(enc(5'd15, 3'd6, 3'd2, 3'd1));
      wait_ready(); dbg_lit("lit_clt_r6", 3'd6, 16'h0001, 16'h0001);
      issue(enc(5'd14, 3'd6, 3'd2, 3'd1));
      wait_ready(); dbg_lit("lit_cgt_r6", 3'd6, 16'h0000, 16'h0000);

      issue(ldi(3'd2, 8'h00)); issue(enc(5'd7, 3'd3, 3'd1, 3'd2));
      wait_ready();
      chk("lit_div0_done", done0, 1); chk("lit_div0_flag", edz0, 1); chk("lit_div0_flag1", edz1, 1);
      dbg_lit("lit_div0_r3", 3'd3, 16'h0008, 16'h0008);
      issue(enc(5'd9, 3'd3, 3'd1, 3'd2));
      wait_ready();
      chk("lit_mod0_flag", edz0, 1);
      dbg_lit("lit_mod0_r3", 3'd3, 16'h0008, 16'h0008);

      issue(enc(5'b00110, 3'd7, 3'd1, 3'd1));
      wait_ready(); chk("lit_ill6_flag", eill0, 1); chk("lit_ill6_done", done0, 1);
      issue(enc(5'b11111, 3'd7, 3'd1, 3'd1));
      wait_ready(); chk("lit_ill31_flag", eill1, 1);
      dbg_lit("lit_ill_r7", 3'd7, 16'h0000, 16'h0000);

      issue(ldi(3'd0, 8'h07));
      wait_ready(); chk("lit_zr_done", done1, 1); chk("lit_zr_err", {eill1, edz1}, 0);
      dbg_lit("lit_zr_r0", 3'd0, 16'h0007, 16'h0000);

      // Hold valid across busy cycles: one accept every four cycles
      acc = 0;
      @(posedge clk); #1;
      instr_valid = 1'b1;
      instr_word  = enc(legal_ops[$urandom_range(0, 15)], 3'($urandom), 3'($urandom), 3'($urandom));
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (ir0) acc++;
         @(posedge clk); #1;
         instr_word = enc(legal_ops[$urandom_range(0, 15)], 3'($urandom), 3'($urandom), 3'($urandom));
      end
      instr_valid = 1'b0;
      chk("lit_throughput", 16'(acc), 16'd4);

      // Reset while the ADD is in EXEC: aborted, no writeback
      wait_ready();
      issue(ldi(3'd3, 8'h08)); issue(ldi(3'd1, 8'hF0)); issue(ldi(3'd2, 8'h01));
      issue(enc(5'd0, 3'd3, 3'd1, 3'd2));
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("lit_abort_done", done0, 0);
      dbg_lit("lit_abort_r3", 3'd3, 16'h0000, 16'h0000);
      issue(ldi(3'd1, 8'h80));
      wait_ready(); dbg_lit("lit_imm_r1", 3'd1, 16'h0080, 16'hFF80);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         instr_valid = ($urandom_range(0, 1) == 1);
         dbg_addr    = 3'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            instr_word = 16'($urandom);
         end else begin
            instr_word = {legal_ops[$urandom_range(0, 15)], 11'($urandom)};
         end
      end
      @(posedge clk); #1 instr_valid = 1'b0;
      repeat (8) @(posedge clk);
      if (q.size() != 0) chk("lit_drain", 16'(q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
